// File: rtl/grasspopper_core.sv
// grasspopper_core: round-iterative Kuznyechik encoder with
// ECB/CTR modes and an in-order tagged output FIFO.
module grasspopper_core #(
  parameter int ROUND_LAT = 1,
  parameter int OUT_DEPTH = 2,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_mode,
  input  logic             ctr_load,
  input  logic [127:0]     ctr_value,
  output logic [127:0]     ctr_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;

  localparam logic [7:0] PI [256] = '{
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16,
    8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA,
    8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21,
    8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0,
    8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB,
    8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12,
    8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7,
    8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E,
    8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9,
    8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC,
    8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44,
    8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F,
    8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7,
    8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE,
    8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B,
    8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0,
    8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };

  // l() coefficients, first entry multiplies the top byte
  localparam logic [7:0] LC [16] = '{
    8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
    8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
  };

  localparam logic [127:0] K9 = 128'h72e9dd7416bcf45b755dbaa88e4a4043;

  function automatic logic [127:0] rkey(input logic [3:0] i);
    logic [127:0] k;
    case (i)
      4'd0:    k = 128'h8899aabbccddeeff0011223344556677;
      4'd1:    k = 128'hfedcba98765432100123456789abcdef;
      4'd2:    k = 128'hdb31485315694343228d6aef8cc78c44;
      4'd3:    k = 128'h3d4553d8e9cfec6815ebadc40a9ffd04;
      4'd4:    k = 128'h57646468c44a5e28d3e59246f429f1ac;
      4'd5:    k = 128'hbd079435165c6432b532e82834da581b;
      4'd6:    k = 128'h51e640757e8745de705727265a0098b1;
      4'd7:    k = 128'h5a7925017b9fdd3ed72a91a22286f984;
      4'd8:    k = 128'hbb44e25378c73123a5f32f73cdb6e517;
      default: k = K9;
    endcase
    return k;
  endfunction

  // GF(2^8) multiply modulo x^8+x^7+x^6+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] lin(input logic [127:0] v);
    logic [127:0] x;
    logic [7:0]   acc;
    x = v;
    for (int r = 0; r < 16; r++) begin
      acc = '0;
      for (int j = 0; j < 16; j++)
        acc = acc ^ gmul(x[127-8*j -: 8], LC[j]);
      x = {acc, x[127:8]};
    end
    return x;
  endfunction

  function automatic logic [127:0] sub(input logic [127:0] v);
    logic [127:0] s;
    for (int i = 0; i < 16; i++)
      s[8*i +: 8] = PI[v[8*i +: 8]];
    return s;
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  state_t           state;
  logic [3:0]       rnd;
  logic [SW-1:0]    sub_cnt;
  logic [127:0]     x_q;
  logic [127:0]     pad_q;
  logic [TAG_W-1:0] tag_q;
  logic             mode_q;
  logic [127:0]     ctr_q;

  logic             accept;
  logic             sub_last;
  logic [127:0]     ctr_use;
  logic [127:0]     round_out;
  logic [127:0]     result;

  logic [127:0]     dmem [OUT_DEPTH];
  logic [TAG_W-1:0] tmem [OUT_DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             ov_q;
  logic             push;
  logic             pop;

  assign in_ready = reset && (state == IDLE) &&
                    (cnt < CW'(OUT_DEPTH));
  assign accept   = in_valid && in_ready;
  assign sub_last = (sub_cnt == SW'(ROUND_LAT - 1));
  assign ctr_use  = ctr_load ? ctr_value : ctr_q;
  assign result   = x_q ^ K9 ^ (mode_q ? pad_q : '0);

  always_comb begin
    round_out = lin(sub(x_q ^ rkey(rnd)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rnd     <= '0;
      sub_cnt <= '0;
      x_q     <= '0;
      pad_q   <= '0;
      tag_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          state   <= ROUND;
          rnd     <= '0;
          sub_cnt <= '0;
          tag_q   <= in_tag;
          mode_q  <= in_mode;
          x_q     <= in_mode ? ctr_use : in_data;
          pad_q   <= in_mode ? in_data : '0;
        end
        ROUND: if (sub_last) begin
          sub_cnt <= '0;
          x_q     <= round_out;
          if (rnd == 4'd8) state <= FINAL;
          else rnd <= rnd + 4'd1;
        end else begin
          sub_cnt <= sub_cnt + SW'(1);
        end
        FINAL: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // a load coinciding with a CTR accept feeds the block directly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ctr_q <= '0;
    else if (accept && in_mode) ctr_q <= ctr_use + 128'd1;
    else if (ctr_load) ctr_q <= ctr_value;
  end

  assign push    = (state == FINAL);
  assign pop     = ov_q && out_ready;
  assign cnt_nxt = cnt + CW'(push) - CW'(pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      ov_q <= 1'b0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      cnt  <= cnt_nxt;
      ov_q <= (cnt_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dmem[wp] <= result;
      tmem[wp] <= tag_q;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = ov_q ? dmem[rp] : '0;
  assign out_tag   = ov_q ? tmem[rp] : '0;
  assign busy      = (state != IDLE);
  assign ctr_o     = ctr_q;

endmodule
